trace_drain_ctrl: RTL and testbench

TRACE_DRAIN_CTRL -- requirements
Module: trace_drain_ctrl

---
 rtl/gouram_trace_pkg.sv | 28 ++
 rtl/sat_counter.sv | 34 +++
 rtl/trace_drain_ctrl.sv | 103 ++++++++++
 tb/tb_trace_drain_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gouram_trace_pkg.sv
// Shared definitions for the trace drain path: record geometry, beat indexing
// and the drain FSM state type.
package gouram_trace_pkg;

  localparam int TRACE_RECORD_WIDTH = 160;
  localparam int TRACE_WORD_WIDTH   = 32;
  localparam int TRACE_BEATS        = 5;

  // Beat index is sized from the beat count so the record geometry lives in one place.
  localparam int BEAT_IDX_WIDTH = (TRACE_BEATS > 1) ? $clog2(TRACE_BEATS) : 1;

  typedef logic [TRACE_RECORD_WIDTH-1:0] trace_record_t;
  typedef logic [TRACE_WORD_WIDTH-1:0]   trace_word_t;
  typedef logic [BEAT_IDX_WIDTH-1:0]     beat_idx_t;

  localparam beat_idx_t FIRST_BEAT = '0;
  localparam beat_idx_t LAST_BEAT  = beat_idx_t'(TRACE_BEATS - 1);

  typedef enum logic [0:0] {
    DRAIN_IDLE   = 1'b0,
    DRAIN_STREAM = 1'b1
  } drain_state_e;

  function automatic beat_idx_t next_beat(input beat_idx_t idx);
    return (idx == LAST_BEAT) ? FIRST_BEAT : beat_idx_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;

  assign at_max = &count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !at_max) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/trace_drain_ctrl.sv
// Latches one completed trace record and drains it as 32-bit beats, LS word first;
// strobes arriving while a record is in flight are counted as drops.
module trace_drain_ctrl
  import gouram_trace_pkg::*;
#(
  parameter int DROP_COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TRACE_RECORD_WIDTH-1:0] trace_data_i,
  input  logic                          trace_ready_i,
  input  logic                          trace_capture_enable_i,
  output logic                          record_ack_o,
  output logic [TRACE_WORD_WIDTH-1:0]   m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic [DROP_COUNT_WIDTH-1:0]   drop_count_o
);

  drain_state_e  state_q, state_d;
  beat_idx_t     beat_q, beat_d;
  trace_record_t record_q, record_d;

  logic          strobe;
  logic          accept;
  logic          drop;
  logic          streaming;

  trace_word_t   record_words [TRACE_BEATS];

  assign strobe    = trace_ready_i && trace_capture_enable_i;
  assign streaming = (state_q == DRAIN_STREAM);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    record_d = record_q;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (strobe) begin
          accept   = 1'b1;
          record_d = trace_data_i;
          beat_d   = FIRST_BEAT;
          state_d  = DRAIN_STREAM;
        end
      end
      DRAIN_STREAM: begin
        // The held record is never overwritten mid-drain; a new strobe is only counted.
        drop = strobe;
        if (m_ready_i) begin
          beat_d = next_beat(beat_q);
          if (beat_q == LAST_BEAT) begin
            state_d = DRAIN_IDLE;
          end
        end
      end
      default: begin
        state_d = DRAIN_IDLE;
        beat_d  = FIRST_BEAT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DRAIN_IDLE;
      beat_q   <= FIRST_BEAT;
      record_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      record_q <= record_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TRACE_BEATS; gi++) begin : g_word_split
      assign record_words[gi] = record_q[gi*TRACE_WORD_WIDTH +: TRACE_WORD_WIDTH];
    end
  endgenerate

  // Beat outputs come purely from held state, so m_valid_o has no path from m_ready_i.
  assign m_valid_o    = streaming;
  assign m_data_o     = streaming ? record_words[beat_q] : '0;
  assign m_last_o     = streaming && (beat_q == LAST_BEAT);
  assign busy_o       = streaming;
  assign record_ack_o = accept;

  sat_counter #(
    .WIDTH (DROP_COUNT_WIDTH)
  ) u_drop_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (drop),
    .count_o (drop_count_o)
  );

endmodule

// File: tb/tb_trace_drain_ctrl.sv
// Randomized and directed bench for trace_drain_ctrl against a queue-based record model.
module tb_trace_drain_ctrl;

  logic         clk;
  logic         rst_n;
  logic [159:0] trace_data;
  logic         trace_ready;
  logic         capture_en;
  logic         m_ready;

  logic         ack, ack_s;
  logic [31:0]  m_data, m_data_s;
  logic         m_valid, m_valid_s;
  logic         m_last, m_last_s;
  logic         busy, busy_s;
  logic [31:0]  drop_count;
  logic [1:0]   drop_count_s;

  int checks;
  int failures;

  // Reference model: words still owed for the current record, plus drop totals.
  logic [31:0] pending[$];
  longint      exp_drop;
  int          exp_drop_sat;

  trace_drain_ctrl dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .trace_data_i           (trace_data),
    .trace_ready_i          (trace_ready),
    .trace_capture_enable_i (capture_en),
    .record_ack_o           (ack),
    .m_data_o               (m_data),
    .m_valid_o              (m_valid),
    .m_ready_i              (m_ready),
    .m_last_o               (m_last),
    .busy_o                 (busy),
    .drop_count_o           (drop_count)
  );

  trace_drain_ctrl #(
    .DROP_COUNT_WIDTH (2)
  ) dut_sat (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .trace_data_i           (trace_data),
    .trace_ready_i          (trace_ready),
    .trace_capture_enable_i (capture_en),
    .record_ack_o           (ack_s),
    .m_data_o               (m_data_s),
    .m_valid_o              (m_valid_s),
    .m_ready_i              (m_ready),
    .m_last_o               (m_last_s),
    .busy_o                 (busy_s),
    .drop_count_o           (drop_count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs, then advance the model.
  task automatic drive_cycle(input logic rdy, input logic en, input logic mrdy,
                             input logic [159:0] data);
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_ack;
    logic        strobe;
    @(negedge clk);
    trace_ready = rdy;
    capture_en  = en;
    m_ready     = mrdy;
    trace_data  = data;
    #1;
    strobe    = rdy && en;
    exp_valid = (pending.size() != 0);
    exp_data  = exp_valid ? pending[0] : 32'h0;
    exp_last  = (pending.size() == 1);
    exp_ack   = !exp_valid && strobe;
    check_eq("m_valid", 64'(m_valid), 64'(exp_valid));
    check_eq("busy", 64'(busy), 64'(exp_valid));
    check_eq("record_ack", 64'(ack), 64'(exp_ack));
    check_eq("m_last", 64'(m_last), 64'(exp_last));
    if (exp_valid) check_eq("m_data", 64'(m_data), 64'(exp_data));
    check_eq("drop_count", 64'(drop_count), 64'(exp_drop));
    check_eq("drop_count_sat2", 64'(drop_count_s), 64'(exp_drop_sat));
    check_eq("sat_dut_m_data", 64'(m_data_s), 64'(m_data));
    $display("cyc rdy=%0b en=%0b mrdy=%0b ack=%0b valid=%0b data=%08h last=%0b drop=%0d sat=%0d",
             rdy, en, mrdy, ack, m_valid, m_data, m_last, drop_count, drop_count_s);
    if (exp_valid && strobe) begin
      exp_drop++;
      if (exp_drop_sat < 3) exp_drop_sat++;
    end
    if (exp_ack) begin
      for (int k = 0; k < 5; k++) pending.push_back(data[k*32 +: 32]);
    end else if (exp_valid && mrdy) begin
      void'(pending.pop_front());
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b1, 160'h0);
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    trace_ready = 1'b0;
    m_ready     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_m_valid", 64'(m_valid), 64'h0);
    check_eq("rst_m_last", 64'(m_last), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_ack", 64'(ack), 64'h0);
    check_eq("rst_drop", 64'(drop_count), 64'h0);
    check_eq("rst_drop_sat", 64'(drop_count_s), 64'h0);
    $display("reset asserted mid-cycle valid=%0b busy=%0b", m_valid, busy);
    pending.delete();
    exp_drop     = 0;
    exp_drop_sat = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [159:0] rand_record();
    logic [159:0] r;
    for (int k = 0; k < 5; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  localparam logic [159:0] REC_A =
    160'h44444444_33333333_22222222_11111111_00000000;

  initial begin
    checks       = 0;
    failures     = 0;
    exp_drop     = 0;
    exp_drop_sat = 0;
    rst_n        = 1'b0;
    trace_ready  = 1'b0;
    capture_en   = 1'b0;
    m_ready      = 1'b0;
    trace_data   = '0;
    #1;
    check_eq("reset_m_valid", 64'(m_valid), 64'h0);
    check_eq("reset_busy", 64'(busy), 64'h0);
    check_eq("reset_drop", 64'(drop_count), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic record, always ready.
    drive_cycle(1'b1, 1'b1, 1'b1, REC_A);
    idle_cycles(6);

    // Stall three cycles on beat 2.
    drive_cycle(1'b1, 1'b1, 1'b1, REC_A);
    drive_cycle(1'b0, 1'b1, 1'b1, 160'h0);
    drive_cycle(1'b0, 1'b1, 1'b1, 160'h0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 160'h0);
    idle_cycles(5);

    // Second strobe two cycles after the first is dropped.
    drive_cycle(1'b1, 1'b1, 1'b1, REC_A);
    drive_cycle(1'b0, 1'b1, 1'b1, 160'h0);
    drive_cycle(1'b1, 1'b1, 1'b1, ~REC_A);
    idle_cycles(5);

    // Strobe without capture enable is ignored; enable falling mid-record does not abort.
    drive_cycle(1'b1, 1'b0, 1'b1, REC_A);
    idle_cycles(2);
    drive_cycle(1'b1, 1'b1, 1'b1, rand_record());
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 1'b1, 160'h0);

    // Reset at beat 2, then a fresh record from beat 0.
    drive_cycle(1'b1, 1'b1, 1'b1, REC_A);
    drive_cycle(1'b0, 1'b1, 1'b1, 160'h0);
    drive_cycle(1'b0, 1'b1, 1'b1, 160'h0);
    reset_mid_cycle();
    idle_cycles(2);

    // Five drops on a stalled record: the 2-bit counter saturates at 3.
    drive_cycle(1'b1, 1'b1, 1'b0, REC_A);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b0, rand_record());
    idle_cycles(8);

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_mid_cycle();
      drive_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 9) < 7), rand_record());
    end
    idle_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
